// File: rtl/lsu_mem_stage.sv
// RV32I MEM stage: word-organised data memory with byte lanes, behind a valid/ready handshake with wait states.
// Optional build macro LSU_MISALIGN_TRAP_EN faults misaligned halfword/word accesses instead of forcing alignment.
module lsu_mem_stage #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault
);
  localparam int         AW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  // state | meaning
  // IDLE  | ready; accepts a request (performed at once when WAIT_STATES=0)
  // WAIT  | request latched; cnt counts down to the access edge
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
  state_t state, state_next;

  logic [3:0]    cnt;
  logic          lat_read, lat_write;
  logic [2:0]    lat_funct3;
  logic [AW+1:0] lat_addr;
  logic [31:0]   lat_wdata;
  logic [31:0]   mem [DEPTH];

  logic          accept, do_access;
  logic          acc_read, acc_write;
  logic [2:0]    acc_funct3;
  logic [AW+1:0] acc_addr;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          is_half, is_word, legal, misalign, fault, wr_en;
  logic [3:0]    be;
  logic [31:0]   wr_data, rd_word, rd_shift, load_data;
  logic          unused_addr;

  assign unused_addr = ^req_addr[31:AW+2];
  assign accept      = req_valid && req_ready;
  assign do_access   = rst_n && ((state == IDLE && accept && WS == 4'd0) ||
                                 (state == WAIT && cnt == 4'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && WS != 4'd0) state_next = WAIT;
      WAIT:    if (cnt == 4'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    case (state)
      IDLE:    req_ready = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      lat_read   <= 1'b0;
      lat_write  <= 1'b0;
      lat_funct3 <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else if (state == IDLE) begin
      if (accept && WS != 4'd0) begin
        cnt        <= WS;
        lat_read   <= req_read;
        lat_write  <= req_write;
        lat_funct3 <= req_funct3;
        lat_addr   <= req_addr[AW+1:0];
        lat_wdata  <= req_wdata;
      end
    end else begin
      cnt <= cnt - 4'd1;
    end
  end

  // In WAIT the access uses the latched request; inputs are ignored until IDLE.
  always_comb begin
    if (state == WAIT) begin
      acc_read   = lat_read;
      acc_write  = lat_write;
      acc_funct3 = lat_funct3;
      acc_addr   = lat_addr;
      acc_wdata  = lat_wdata;
    end else begin
      acc_read   = req_read;
      acc_write  = req_write;
      acc_funct3 = req_funct3;
      acc_addr   = req_addr[AW+1:0];
      acc_wdata  = req_wdata;
    end
  end

  assign idx     = acc_addr[AW+1:2];
  assign is_half = (acc_funct3[1:0] == 2'b01);
  assign is_word = (acc_funct3[1:0] == 2'b10);

  always_comb begin
    legal = 1'b0;
    if (acc_read && acc_write) begin
      legal = 1'b0;
    end else if (acc_read) begin
      case (acc_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        default:                                legal = 1'b0;
      endcase
    end else if (acc_write) begin
      case (acc_funct3)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        default:                legal = 1'b0;
      endcase
    end else begin
      legal = 1'b1;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (acc_read ^ acc_write) &&
                    ((is_half && acc_addr[0]) || (is_word && acc_addr[1:0] != 2'b00));
  assign off      = acc_addr[1:0];
`else
  assign misalign = 1'b0;
  assign off      = is_word ? 2'b00 : (is_half ? {acc_addr[1], 1'b0} : acc_addr[1:0]);
`endif

  assign fault = !legal || misalign;
  assign wr_en = do_access && acc_write && !fault;

  always_comb begin
    be      = 4'b1111;
    wr_data = acc_wdata;
    if (is_half) begin
      be      = 4'b0011 << off;
      wr_data = {2{acc_wdata[15:0]}};
    end else if (!is_word) begin
      be      = 4'b0001 << off;
      wr_data = {4{acc_wdata[7:0]}};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  assign rd_word  = mem[idx];
  assign rd_shift = rd_word >> {off, 3'b000};

  always_comb begin
    case (acc_funct3)
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_data = {24'b0, rd_shift[7:0]};
      3'b101:  load_data = {16'b0, rd_shift[15:0]};
      default: load_data = rd_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end else begin
      resp_valid <= do_access;
      if (do_access) begin
        resp_fault <= fault;
        resp_rdata <= (acc_read && !fault) ? load_data : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: two instances (0 and 3 wait states) checked every cycle against a byte-level model.
module tb_lsu_mem_stage;
  localparam int DEPTH = 1024;
  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       req_valid, req_read, req_write, req_ready, resp_valid, resp_fault;
  logic [1:0][2:0]  req_funct3;
  logic [1:0][31:0] req_addr, req_wdata, resp_rdata;

  lsu_mem_stage #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_read(req_read[0]), .req_write(req_write[0]), .req_funct3(req_funct3[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
    .resp_rdata(resp_rdata[0]), .resp_fault(resp_fault[0]));

  lsu_mem_stage #(.DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_read(req_read[1]), .req_write(req_write[1]), .req_funct3(req_funct3[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
    .resp_rdata(resp_rdata[1]), .resp_fault(resp_fault[1]));

  function automatic int ws_of(int u);
    return (u == 0) ? 0 : 3;
  endfunction

  // hand-computed expectation attached to the next request of each unit
  logic [1:0]       lit_en = '0, lit_fault = '0;
  logic [1:0][31:0] lit_rdata = '0;

  // model state
  logic [7:0]       mb [2][4*DEPTH];
  logic [1:0]       pend = '0, p_read = '0, p_write = '0, p_lit_en = '0, p_lit_fault = '0;
  logic [1:0][2:0]  p_funct3 = '0;
  logic [1:0][31:0] p_addr = '0, p_wdata = '0, p_lit_rdata = '0;
  int               due [2];
  int               cyc = 0;
  logic [1:0]       exp_valid = '0, exp_fault = '0, exp_lit_en = '0, exp_lit_fault = '0;
  logic [1:0][31:0] exp_rdata = '0, exp_lit_rdata = '0;

  int n_vec = 0;
  int n_bad = 0;

  task automatic model_exec(int u);
    int a, n;
    logic [31:0] v;
    logic f;
    v = 32'h0;
    f = 1'b0;
    a = int'(p_addr[u] % (4 * DEPTH));
    case (p_funct3[u][1:0])
      2'd0: n = 1;
      2'd1: n = 2;
      2'd2: n = 4;
      default: n = 0;
    endcase
    if (p_read[u] && p_write[u]) begin
      f = 1'b1;
    end else if (p_read[u] || p_write[u]) begin
      if (n == 0 || (p_write[u] && p_funct3[u][2]) || (p_read[u] && p_funct3[u][2] && n == 4))
        f = 1'b1;
      else if (a % n != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
        f = 1'b1;
`else
        a = a - (a % n);
`endif
      end
      if (!f) begin
        for (int i = 0; i < n; i++) begin
          if (p_write[u]) mb[u][a+i] = p_wdata[u][8*i +: 8];
          else            v[8*i +: 8] = mb[u][a+i];
        end
        if (p_read[u] && !p_funct3[u][2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      end
    end
    exp_valid[u]     = 1'b1;
    exp_rdata[u]     = v;
    exp_fault[u]     = f;
    exp_lit_en[u]    = p_lit_en[u];
    exp_lit_rdata[u] = p_lit_rdata[u];
    exp_lit_fault[u] = p_lit_fault[u];
  endtask

  // model: a unit is busy from accept until its response edge; reset drops everything in flight
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      pend      = '0;
      exp_valid = '0;
      exp_rdata = '0;
      exp_fault = '0;
    end else begin
      cyc++;
      for (int u = 0; u < 2; u++) begin
        exp_valid[u] = 1'b0;
        if (pend[u]) begin
          if (cyc == due[u]) begin
            model_exec(u);
            pend[u] = 1'b0;
          end
        end else if (req_valid[u]) begin
          p_read[u]      = req_read[u];
          p_write[u]     = req_write[u];
          p_funct3[u]    = req_funct3[u];
          p_addr[u]      = req_addr[u];
          p_wdata[u]     = req_wdata[u];
          p_lit_en[u]    = lit_en[u];
          p_lit_rdata[u] = lit_rdata[u];
          p_lit_fault[u] = lit_fault[u];
          due[u]         = cyc + ws_of(u);
          if (ws_of(u) == 0) model_exec(u);
          else               pend[u] = 1'b1;
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("req_ready[%0d]", u), 32'(req_ready[u]), 32'(!pend[u]));
      chk($sformatf("resp_valid[%0d]", u), 32'(resp_valid[u]), 32'(exp_valid[u]));
      chk($sformatf("resp_rdata[%0d]", u), resp_rdata[u], exp_rdata[u]);
      chk($sformatf("resp_fault[%0d]", u), 32'(resp_fault[u]), 32'(exp_fault[u]));
      if (exp_valid[u] && exp_lit_en[u]) begin
        chk($sformatf("literal_rdata[%0d]", u), resp_rdata[u], exp_lit_rdata[u]);
        chk($sformatf("literal_fault[%0d]", u), 32'(resp_fault[u]), 32'(exp_lit_fault[u]));
      end
    end
  end

  // present a request (called at posedge+2), hold through the accept edge, then scramble inputs during WAIT
  task automatic go(int u, logic rd, logic wr, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                    logic le = 1'b0, logic [31:0] lr = 32'h0, logic lf = 1'b0);
    lit_en[u]     = le;
    lit_rdata[u]  = lr;
    lit_fault[u]  = lf;
    req_valid[u]  = 1'b1;
    req_read[u]   = rd;
    req_write[u]  = wr;
    req_funct3[u] = f3;
    req_addr[u]   = a;
    req_wdata[u]  = wd;
    @(posedge clk); #2;
    if (ws_of(u) > 0) begin
      req_read[u]   = 1'($urandom);
      req_write[u]  = 1'($urandom);
      req_funct3[u] = 3'($urandom);
      req_addr[u]   = $urandom;
      req_wdata[u]  = $urandom;
      repeat (ws_of(u)) @(posedge clk);
      #2;
    end
    req_valid[u] = 1'b0;
  endtask

  task automatic ld(int u, logic [2:0] f3, logic [31:0] a, logic [31:0] lr, logic lf = 1'b0);
    go(u, 1'b1, 1'b0, f3, a, 32'h0, 1'b1, lr, lf);
  endtask

  task automatic st(int u, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    go(u, 1'b0, 1'b1, f3, a, wd);
  endtask

  initial begin
    req_valid = '0; req_read = '0; req_write = '0;
    req_funct3 = '0; req_addr = '0; req_wdata = '0;
    #20 rst_n = 1'b1;
    @(posedge clk); #2;

    // zero wait states, back-to-back
    st(0, F_W, 32'h4, 32'h1234_5678);
    ld(0, F_W, 32'h4, 32'h1234_5678);
    st(0, F_W, 32'h0, 32'hAAAA_AAAA);
    st(0, F_B, 32'h2, 32'h0000_0080);
    ld(0, F_W, 32'h0, 32'hAA80_AAAA);
    ld(0, F_B, 32'h2, 32'hFFFF_FF80);
    ld(0, F_BU, 32'h2, 32'h0000_0080);
    st(0, F_H, 32'h0, 32'h0000_8001);
    ld(0, F_H, 32'h0, 32'hFFFF_8001);
    ld(0, F_HU, 32'h0, 32'h0000_8001);
    st(0, F_W, 32'h1000, 32'hCCCC_CCCC);
    ld(0, F_W, 32'h0, 32'hCCCC_CCCC);
`ifdef LSU_MISALIGN_TRAP_EN
    ld(0, F_W, 32'h1, 32'h0, 1'b1);
    go(0, 1'b0, 1'b1, F_H, 32'h3, 32'h0000_1234, 1'b1, 32'h0, 1'b1);
    ld(0, F_W, 32'h0, 32'hCCCC_CCCC);
    ld(0, F_H, 32'h2, 32'hFFFF_CCCC);
`else
    ld(0, F_W, 32'h1, 32'hCCCC_CCCC);
    go(0, 1'b0, 1'b1, F_H, 32'h3, 32'h0000_1234, 1'b1, 32'h0, 1'b0);
    ld(0, F_W, 32'h0, 32'h1234_CCCC);
    ld(0, F_H, 32'h2, 32'h0000_1234);
`endif
    go(0, 1'b0, 1'b1, 3'b011, 32'h0, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1);
    go(0, 1'b0, 1'b1, 3'b100, 32'h0, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1);
    go(0, 1'b1, 1'b1, F_W, 32'h0, 32'h5555_5555, 1'b1, 32'h0, 1'b1);
    go(0, 1'b0, 1'b0, F_W, 32'h4, 32'h0, 1'b1, 32'h0, 1'b0);
    ld(0, 3'b110, 32'h4, 32'h0, 1'b1);
`ifdef LSU_MISALIGN_TRAP_EN
    ld(0, F_W, 32'h0, 32'hCCCC_CCCC);
`else
    ld(0, F_W, 32'h0, 32'h1234_CCCC);
`endif

    // three wait states, inputs scrambled during WAIT
    st(1, F_W, 32'h8, 32'h1111_2222);
    ld(1, F_W, 32'h8, 32'h1111_2222);
    st(1, F_B, 32'hB, 32'h0000_005A);
    ld(1, F_W, 32'h8, 32'h5A11_2222);

    // reset during WAIT abandons the store
    req_valid[1] = 1'b1; req_read[1] = 1'b0; req_write[1] = 1'b1;
    req_funct3[1] = F_W; req_addr[1] = 32'h8; req_wdata[1] = 32'hDEAD_BEEF;
    @(posedge clk); #2;
    req_valid[1] = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;
    ld(1, F_W, 32'h8, 32'h5A11_2222);
    ld(1, F_HU, 32'hA, 32'h0000_5A11);
    ld(1, F_H, 32'h8, 32'h0000_2222);

    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Parametrised MEM pipeline stage with a word-organised data memory supporting RV32I byte, halfword and word loads and stores. Loads are sign- or zero-extended. Access latency is configurable through a wait-state counter behind a valid/ready request handshake. It sits between the EX/MEM register and the MEM/WB register. It supersedes the word-only, zero-latency data memory stage.

## Interface
- `DEPTH`, 1024, number of 32-bit words; power of two, ≥4
- `WAIT_STATES`, 0, extra cycles per access (0–15)
- `clk` in 1 system clock, rising edge
- `rst_n` in 1 asynchronous active-low reset
- `req_valid` in 1 request present
- `req_ready` out 1 stage can accept a request
- `req_read` in 1 load request
- `req_write` in 1 store request
- `req_funct3` in 3 RV32I width/sign code
- `req_addr` in 32 byte address (ALU result)
- `req_wdata` in 32 store data (rs2); low byte/halfword used for SB/SH
- `resp_valid` out 1 one-cycle pulse: access complete
- `resp_rdata` out 32 extended load data; 0 for stores, faults and no-ops
- `resp_fault` out 1 misaligned or illegal access; valid with `resp_valid`

## Operation
- Word index is `req_addr[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses alias modulo 4·DEPTH bytes.
- Memory is not reset; contents are X until written.
- Funct3 mapping:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal: `resp_fault`=1, no memory update.
- Stores write only the addressed byte lanes via byte enables (`addr[1:0]` selects the lane). Other bytes of the word are preserved.
- Loads select the lane by `addr[1:0]`:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
- `req_read` && `req_write` both high: fault, no access.
- Both low: no-op, `resp_valid` still pulses with rdata 0, fault 0.
- FSM:
  - IDLE: `req_ready`=1. On accept (`req_valid`&&`req_ready`):
    - `WAIT_STATES`=0: perform the access at that edge and stay in IDLE.
    - Otherwise: latch the request, load `cnt`=`WAIT_STATES`, go to WAIT.
  - WAIT: `req_ready`=0. `cnt` decrements each edge. At the edge where `cnt`==1, perform the latched access, pulse `resp_valid`, and return to IDLE.
- Request inputs are sampled only at the accept edge; changes during WAIT are ignored.

## Timing
- Reset values: `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_fault`=0, state IDLE, `cnt`=0.
- Latency: `resp_valid` is high in the cycle following edge (accept edge + `WAIT_STATES`), i.e. WAIT_STATES+1 cycles after `req_valid` is presented.
- Throughput: 1 access per WAIT_STATES+1 cycles. With `WAIT_STATES`=0, back-to-back requests are accepted every cycle.
- `req_ready` returns high in the same cycle `resp_valid` pulses, so a new request can be accepted in that cycle.
- Store followed immediately by a load to the same word returns the new data, since accesses are serialised.
- `resp_rdata`/`resp_fault` hold their values until the next response. Only `resp_valid` is a pulse.
- Reset asserted mid-WAIT: the latched access is abandoned with no memory write, and outputs go to their reset values immediately.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Halfword access with `addr[0]`≠0, or word access with `addr[1:0]`≠0, sets `resp_fault`=1.
  - No memory write; rdata is 0.
- Not defined:
  - Misaligned halfwords are forced to `addr[1]` alignment (`addr[0]` ignored).
  - Words are forced to word alignment (`addr[1:0]` ignored).
  - `resp_fault` is never set by alignment.

## Test plan
- Reset held 20 ns, then release: ready=1, resp_valid=0, rdata=0, fault=0. SW 0x12345678 @0x4, then LW @0x4 → rdata 0x12345678, fault 0.
- Byte-lane test:
  - SW 0xAAAAAAAA @0x0, then SB 0x80 @0x2 → LW @0x0 returns 0xAA80AAAA.
  - LB @0x2 → 0xFFFFFF80; LBU @0x2 → 0x00000080.
  - SH 0x8001 @0x0 → LH @0x0 = 0xFFFF8001, LHU = 0x00008001.
- Alias/wrap with DEPTH=1024: SW 0xCCCCCCCC @0x1000 → LW @0x0 returns 0xCCCCCCCC.
- Misaligned LW @0x1 and SH @0x3:
  - With `LSU_MISALIGN_TRAP_EN`: fault=1, rdata 0, memory at 0x0 unchanged.
  - Without: LW @0x1 reads word 0x0, fault=0.
- `WAIT_STATES`=3: the accept edge is followed by exactly 3 cycles of ready=0. `resp_valid` pulses for one cycle 4 cycles after `req_valid`. Inputs changed during WAIT do not affect the result.
- Mid-operation and illegal cases:
  - Assert `rst_n`=0 during WAIT of a SW 0xDEADBEEF @0x8 → word 0x8 keeps its prior value, outputs at reset values.
  - funct3=011 store → fault=1.
  - read&&write both high → fault=1.
